// File: rtl/csi_pckt_handler.sv
// CSI-2 style packet parser: header decode, frame tracking, payload extraction with byte enables.
// Optional VC_FILTER_EN: drop packets whose virtual channel differs from parameter VC.
module csi_pckt_handler #(
  parameter int         LANES = 2,
  parameter logic [1:0] VC    = 2'd0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [8*LANES-1:0] din,
  input  logic               din_valid,
  output logic [8*LANES-1:0] dout,
  output logic [LANES-1:0]   dout_be,
  output logic               dout_valid,
  output logic               fr_active,
  output logic               fr_valid,
  output logic [15:0]        line_count,
  output logic               err_trunc
);

  localparam logic [15:0] LANES_W = 16'(LANES);
  localparam logic [2:0]  LANES_H = 3'(LANES);

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, FOOTER, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [31:0]        hdr_q, hdr_d;
  logic [2:0]         hdr_cnt_q, hdr_cnt_d;
  logic [15:0]        rem_q, rem_d;
  logic [1:0]         ftr_q, ftr_d;
  logic [8*LANES-1:0] dout_q, dout_d;
  logic [LANES-1:0]   be_q, be_d;
  logic               dv_q, dv_d;
  logic               fr_active_q, fr_active_d;
  logic [15:0]        line_q, line_d;
  logic               err_q, err_d;

  logic [31:0]        hdr_next;
  logic               hdr_last;
  logic [15:0]        wc;
  logic               vc_ok;
  logic [15:0]        n_pay;
  logic [15:0]        fb;
  logic [LANES-1:0]   be_calc;

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      hdr_q       <= 32'd0;
      hdr_cnt_q   <= 3'd0;
      rem_q       <= 16'd0;
      ftr_q       <= 2'd0;
      dout_q      <= '0;
      be_q        <= '0;
      dv_q        <= 1'b0;
      fr_active_q <= 1'b0;
      line_q      <= 16'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      hdr_cnt_q   <= hdr_cnt_d;
      rem_q       <= rem_d;
      ftr_q       <= ftr_d;
      dout_q      <= dout_d;
      be_q        <= be_d;
      dv_q        <= dv_d;
      fr_active_q <= fr_active_d;
      line_q      <= line_d;
      err_q       <= err_d;
    end
  end

  // Next-state, header decode and payload/footer accounting
  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    hdr_cnt_d   = hdr_cnt_q;
    rem_d       = rem_q;
    ftr_d       = ftr_q;
    dout_d      = dout_q;
    be_d        = '0;
    dv_d        = 1'b0;
    fr_active_d = fr_active_q;
    line_d      = line_q;
    err_d       = 1'b0;

    // Header bytes shift in from the right; byte 0 ends up in [31:24]
    hdr_next = 32'({hdr_q, din});
    hdr_last = ((hdr_cnt_q + LANES_H) == 3'd4);
    wc       = {hdr_next[15:8], hdr_next[23:16]};
`ifdef VC_FILTER_EN
    vc_ok    = (hdr_next[31:30] == VC);
`else
    vc_ok    = 1'b1 | (hdr_next[31:30] == VC);
`endif
    n_pay    = (rem_q < LANES_W) ? rem_q : LANES_W;
    fb       = LANES_W - n_pay;
    be_calc  = '0;
    for (int i = 0; i < LANES; i++) begin
      be_calc[LANES-1-i] = (16'(i) < n_pay);
    end

    case (state_q)
      IDLE, HDR: begin
        if (din_valid) begin
          hdr_d = hdr_next;
          if (hdr_last) begin
            hdr_cnt_d = 3'd0;
            if (!vc_ok) begin
              state_d = DRAIN;
            end else if (hdr_next[29:24] < 6'h10) begin
              state_d = DRAIN;
              if (hdr_next[29:24] == 6'h00) begin
                fr_active_d = 1'b1;
                line_d      = 16'd0;
              end else if (hdr_next[29:24] == 6'h01) begin
                fr_active_d = 1'b0;
              end else begin
                fr_active_d = fr_active_q;
              end
            end else begin
              rem_d = wc;
              if (wc == 16'd0) begin
                state_d = FOOTER;
                ftr_d   = 2'd2;
              end else begin
                state_d = PAYLOAD;
              end
            end
          end else begin
            hdr_cnt_d = hdr_cnt_q + LANES_H;
            state_d   = HDR;
          end
        end else if (state_q == HDR) begin
          err_d     = 1'b1;
          state_d   = IDLE;
          hdr_cnt_d = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      PAYLOAD: begin
        if (din_valid) begin
          if (fr_active_q) begin
            dout_d = din;
            be_d   = be_calc;
            dv_d   = 1'b1;
          end else begin
            dv_d = 1'b0;
          end
          if (rem_q <= LANES_W) begin
            rem_d = 16'd0;
            // Trailing bytes of the last payload word belong to the CRC
            if (fb >= 16'd2) begin
              line_d  = fr_active_q ? line_q + 16'd1 : line_q;
              state_d = DRAIN;
            end else begin
              ftr_d   = 2'(16'd2 - fb);
              state_d = FOOTER;
            end
          end else begin
            rem_d = rem_q - LANES_W;
          end
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
          rem_d   = 16'd0;
        end
      end
      FOOTER: begin
        if (din_valid) begin
          if ({14'd0, ftr_q} <= LANES_W) begin
            ftr_d   = 2'd0;
            line_d  = fr_active_q ? line_q + 16'd1 : line_q;
            state_d = DRAIN;
          end else begin
            ftr_d = ftr_q - LANES_W[1:0];
          end
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
          ftr_d   = 2'd0;
        end
      end
      DRAIN: begin
        if (!din_valid) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign dout       = dout_q;
  assign dout_be    = be_q;
  assign dout_valid = dv_q;
  assign fr_valid   = dv_q;
  assign fr_active  = fr_active_q;
  assign line_count = line_q;
  assign err_trunc  = err_q;

endmodule

// File: tb/tb_csi_pckt_handler.sv
// Scoreboard bench for csi_pckt_handler: LANES=2 and LANES=4 instances, VC=0.
module tb_csi_pckt_handler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [15:0] din2, dout2;
  logic [1:0]  be2;
  logic        dv2, dov2, fra2, frv2, err2;
  logic [15:0] lc2;
  logic [31:0] din4, dout4;
  logic [3:0]  be4;
  logic        dv4, dov4, fra4, frv4, err4;
  logic [15:0] lc4;

  int checks   = 0;
  int failures = 0;
  int seen2    = 0;
  int seen4    = 0;

  logic [17:0] exp2_q[$];
  logic [35:0] exp4_q[$];
  logic [15:0] pkt2[$];
  logic [31:0] pkt4[$];
  logic [17:0] e2;
  logic [35:0] e4;
  logic [15:0] m2;
  logic [31:0] m4;

  csi_pckt_handler #(.LANES(2), .VC(2'd0)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .din(din2), .din_valid(dv2),
    .dout(dout2), .dout_be(be2), .dout_valid(dov2), .fr_active(fra2),
    .fr_valid(frv2), .line_count(lc2), .err_trunc(err2)
  );

  csi_pckt_handler #(.LANES(4), .VC(2'd0)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .din(din4), .din_valid(dv4),
    .dout(dout4), .dout_be(be4), .dout_valid(dov4), .fr_active(fra4),
    .fr_valid(frv4), .line_count(lc4), .err_trunc(err4)
  );

  // Scoreboard pop for the two-lane instance
  always @(negedge clk) begin
    if (reset_n && dov2) begin
      seen2++;
      checks++;
      if (exp2_q.size() == 0) begin
        failures++;
        $display("FAIL dout2_unexpected got=%h be=%b required=no output", dout2, be2);
      end else begin
        e2 = exp2_q.pop_front();
        m2 = {{8{e2[17]}}, {8{e2[16]}}};
        if (be2 !== e2[17:16] || (dout2 & m2) !== (e2[15:0] & m2)) begin
          failures++;
          $display("FAIL dout2_word got=%h/%b required=%h/%b", dout2, be2, e2[15:0], e2[17:16]);
        end
      end
      checks++;
      if (frv2 !== 1'b1) begin
        failures++;
        $display("FAIL fr_valid2 got=%b required=1", frv2);
      end
    end
  end

  // Scoreboard pop for the four-lane instance
  always @(negedge clk) begin
    if (reset_n && dov4) begin
      seen4++;
      checks++;
      if (exp4_q.size() == 0) begin
        failures++;
        $display("FAIL dout4_unexpected got=%h be=%b required=no output", dout4, be4);
      end else begin
        e4 = exp4_q.pop_front();
        m4 = {{8{e4[35]}}, {8{e4[34]}}, {8{e4[33]}}, {8{e4[32]}}};
        if (be4 !== e4[35:32] || (dout4 & m4) !== (e4[31:0] & m4)) begin
          failures++;
          $display("FAIL dout4_word got=%h/%b required=%h/%b", dout4, be4, e4[31:0], e4[35:32]);
        end
      end
      checks++;
      if (frv4 !== 1'b1) begin
        failures++;
        $display("FAIL fr_valid4 got=%b required=1", frv4);
      end
    end
  end

  task automatic w2(input logic [15:0] d, input logic v);
    @(posedge clk); #1;
    din2 = d;
    dv2  = v;
  endtask

  task automatic w4(input logic [31:0] d, input logic v);
    @(posedge clk); #1;
    din4 = d;
    dv4  = v;
  endtask

  task automatic send2();
    foreach (pkt2[i]) w2(pkt2[i], 1'b1);
    w2(16'h0000, 1'b0);
    w2(16'h0000, 1'b0);
  endtask

  task automatic send4();
    foreach (pkt4[i]) w4(pkt4[i], 1'b1);
    w4(32'h0, 1'b0);
    w4(32'h0, 1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    din2 = 16'h0; dv2 = 1'b0;
    din4 = 32'h0; dv4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({dout2, be2, dov2, fra2, frv2, lc2, err2} !== 38'd0) begin
      failures++;
      $display("FAIL reset2 got=%h required=0", {dout2, be2, dov2, fra2, frv2, lc2, err2});
    end
    checks++;
    if ({dout4, be4, dov4, fra4, frv4, lc4, err4} !== 56'd0) begin
      failures++;
      $display("FAIL reset4 got=%h required=0", {dout4, be4, dov4, fra4, frv4, lc4, err4});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    w2(16'h0000, 1'b0);
  endtask

  task automatic test_pre_fs();
    int s;
    s = seen2;
    pkt2 = {16'h2B04, 16'h00A5, 16'hDEAD, 16'hBEEF, 16'hC1C2};
    send2();
    checks++;
    if (seen2 !== s) begin
      failures++;
      $display("FAIL pre_fs_silent got=%0d words required=0", seen2 - s);
    end
    checks++;
    if (lc2 !== 16'd0) begin
      failures++;
      $display("FAIL pre_fs_lines got=%0d required=0", lc2);
    end
  endtask

  task automatic test_frame_start();
    w2(16'h0000, 1'b1);
    w2(16'h00EC, 1'b1);
    checks++;
    if (fra2 !== 1'b0) begin
      failures++;
      $display("FAIL fs_early got=%b required=0", fra2);
    end
    w2(16'h0000, 1'b0);
    checks++;
    if (fra2 !== 1'b1 || lc2 !== 16'd0) begin
      failures++;
      $display("FAIL fs_active got=%b/%0d required=1/0", fra2, lc2);
    end
    w2(16'h0000, 1'b0);
  endtask

  task automatic test_long2();
    exp2_q.push_back({2'b11, 16'h1122});
    exp2_q.push_back({2'b11, 16'h3344});
    exp2_q.push_back({2'b11, 16'h5566});
    pkt2 = {16'h2B06, 16'h00A5, 16'h1122, 16'h3344, 16'h5566, 16'hC1C2};
    send2();
    checks++;
    if (lc2 !== 16'd1) begin
      failures++;
      $display("FAIL long2_wc6_lines got=%0d required=1", lc2);
    end
    exp2_q.push_back({2'b11, 16'hAABB});
    exp2_q.push_back({2'b10, 16'hCC00});
    pkt2 = {16'h2B03, 16'h00A5, 16'hAABB, 16'hCCF1, 16'hF200};
    send2();
    checks++;
    if (lc2 !== 16'd2) begin
      failures++;
      $display("FAIL long2_wc3_lines got=%0d required=2", lc2);
    end
    pkt2 = {16'h2B00, 16'h00A5, 16'hC1C2};
    send2();
    checks++;
    if (lc2 !== 16'd3 || exp2_q.size() != 0) begin
      failures++;
      $display("FAIL long2_wc0 got=%0d/%0d pending required=3/0", lc2, exp2_q.size());
    end
  endtask

  task automatic test_trunc();
    exp2_q.push_back({2'b11, 16'h1122});
    w2(16'h2B06, 1'b1);
    w2(16'h00A5, 1'b1);
    w2(16'h1122, 1'b1);
    w2(16'h0000, 1'b0);
    checks++;
    if (err2 !== 1'b0) begin
      failures++;
      $display("FAIL trunc_early got=%b required=0", err2);
    end
    w2(16'h0000, 1'b0);
    checks++;
    if (err2 !== 1'b1) begin
      failures++;
      $display("FAIL trunc_pulse got=%b required=1", err2);
    end
    w2(16'h0000, 1'b0);
    checks++;
    if (err2 !== 1'b0 || lc2 !== 16'd3 || fra2 !== 1'b1) begin
      failures++;
      $display("FAIL trunc_after got=%b/%0d/%b required=0/3/1", err2, lc2, fra2);
    end
    exp2_q.push_back({2'b11, 16'h7788});
    pkt2 = {16'h2B02, 16'h00A5, 16'h7788, 16'hC1C2};
    send2();
    checks++;
    if (lc2 !== 16'd4 || exp2_q.size() != 0) begin
      failures++;
      $display("FAIL trunc_next got=%0d/%0d pending required=4/0", lc2, exp2_q.size());
    end
  endtask

  task automatic test_frame_end();
    int s;
    pkt2 = {16'h0200, 16'h00A5};
    send2();
    checks++;
    if (fra2 !== 1'b1 || lc2 !== 16'd4) begin
      failures++;
      $display("FAIL short_other got=%b/%0d required=1/4", fra2, lc2);
    end
    pkt2 = {16'h0100, 16'h00A5};
    send2();
    checks++;
    if (fra2 !== 1'b0) begin
      failures++;
      $display("FAIL fe_inactive got=%b required=0", fra2);
    end
    s = seen2;
    pkt2 = {16'h2B02, 16'h00A5, 16'h1234, 16'hC1C2};
    send2();
    checks++;
    if (seen2 !== s || lc2 !== 16'd4) begin
      failures++;
      $display("FAIL post_fe_silent got=%0d words/%0d lines required=0/4", seen2 - s, lc2);
    end
  endtask

  task automatic test_vc_filter();
    pkt2 = {16'h4000, 16'h00A5};
    send2();
    checks++;
`ifdef VC_FILTER_EN
    if (fra2 !== 1'b0 || lc2 !== 16'd4) begin
      failures++;
      $display("FAIL vc1_fs_filtered got=%b/%0d required=0/4", fra2, lc2);
    end
`else
    if (fra2 !== 1'b1 || lc2 !== 16'd0) begin
      failures++;
      $display("FAIL vc1_fs_accepted got=%b/%0d required=1/0", fra2, lc2);
    end
`endif
  endtask

  task automatic test_lanes4();
    pkt4 = {32'h000000A5};
    send4();
    checks++;
    if (fra4 !== 1'b1 || lc4 !== 16'd0) begin
      failures++;
      $display("FAIL fs4 got=%b/%0d required=1/0", fra4, lc4);
    end
    exp4_q.push_back({4'b1111, 32'hA1A2A3A4});
    exp4_q.push_back({4'b1000, 32'hA5000000});
    pkt4 = {32'h2B0500A5, 32'hA1A2A3A4, 32'hA5C1C200};
    send4();
    checks++;
    if (lc4 !== 16'd1) begin
      failures++;
      $display("FAIL long4_wc5_lines got=%0d required=1", lc4);
    end
    exp4_q.push_back({4'b1100, 32'hB1B20000});
    pkt4 = {32'h2B0200A5, 32'hB1B2C1C2};
    send4();
    checks++;
    if (lc4 !== 16'd2 || exp4_q.size() != 0) begin
      failures++;
      $display("FAIL long4_wc2 got=%0d/%0d pending required=2/0", lc4, exp4_q.size());
    end
  endtask

  task automatic test_reset_mid();
    pkt2 = {16'h0000, 16'h00A5};
    send2();
    w2(16'h2B06, 1'b1);
    w2(16'h00A5, 1'b1);
    w2(16'h1122, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (fra2 !== 1'b0 || lc2 !== 16'd0 || dov2 !== 1'b0) begin
      failures++;
      $display("FAIL reset_async got=%b/%0d/%b required=0/0/0", fra2, lc2, dov2);
    end
    dv2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    w2(16'h0000, 1'b0);
    pkt2 = {16'h0000, 16'h00A5};
    send2();
    exp2_q.push_back({2'b11, 16'h5A5A});
    pkt2 = {16'h2B02, 16'h00A5, 16'h5A5A, 16'hC1C2};
    send2();
    checks++;
    if (fra2 !== 1'b1 || lc2 !== 16'd1 || exp2_q.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_recover got=%b/%0d/%0d required=1/1/0", fra2, lc2, exp2_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_pre_fs();
    test_frame_start();
    test_long2();
    test_trunc();
    test_frame_end();
    test_vc_filter();
    test_lanes4();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
